// File: rtl/rams_pkg.sv
// Shared definitions for the distributed RAM with clear sequencer.
package rams_pkg;

  // Read-during-write policy selectors.
  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // Clear sequencer states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Number of byte lanes in a word.
  function automatic int unsigned nlanes(input int unsigned data_w, input int unsigned lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/rams_dist_clr_if.sv
// Access bus of the RAM: write port, two read ports and clear control.
interface rams_dist_clr_if
  import rams_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = 8,
  parameter int unsigned ADDR_BITWIDTH = 8,
  parameter int unsigned LANE_BITWIDTH = 8
);
  localparam int unsigned NLANES = nlanes(DATA_BITWIDTH, LANE_BITWIDTH);

  logic                     clr;
  logic                     busy;
  logic                     we;
  logic [NLANES-1:0]        be;
  logic [ADDR_BITWIDTH-1:0] a;
  logic [DATA_BITWIDTH-1:0] di;
  logic                     re_s;
  logic [ADDR_BITWIDTH-1:0] dpra;
  logic                     re_d;
  logic [DATA_BITWIDTH-1:0] spo;
  logic                     spo_vld;
  logic [DATA_BITWIDTH-1:0] dpo;
  logic                     dpo_vld;

  modport master (
    output clr, we, be, a, di, re_s, dpra, re_d,
    input  busy, spo, spo_vld, dpo, dpo_vld
  );

  modport slave (
    input  clr, we, be, a, di, re_s, dpra, re_d,
    output busy, spo, spo_vld, dpo, dpo_vld
  );
endinterface

// File: rtl/rams_dist_lane.sv
// One lane-wide distributed array: single write port, two asynchronous read ports.
module rams_dist_lane #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ADDR_BITWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_BITWIDTH-1:0] wa,
  input  logic [WIDTH-1:0]         wd,
  input  logic [ADDR_BITWIDTH-1:0] ra0,
  input  logic [ADDR_BITWIDTH-1:0] ra1,
  output logic [WIDTH-1:0]         rd0,
  output logic [WIDTH-1:0]         rd1
);
  localparam int unsigned DEPTH = 2 ** ADDR_BITWIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never reset; the clear sequencer owns initialisation.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
endmodule

// File: rtl/rams_dist_clr.sv
// Byte-enabled distributed RAM with two registered read ports and a clear sequencer.
module rams_dist_clr
  import rams_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = 8,
  parameter int unsigned ADDR_BITWIDTH = 8,
  parameter int unsigned LANE_BITWIDTH = 8,
  parameter int unsigned RDW_MODE      = RDW_READ_FIRST,
  parameter logic [DATA_BITWIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  rams_dist_clr_if.slave  bus
);
  localparam int unsigned NLANES = nlanes(DATA_BITWIDTH, LANE_BITWIDTH);
  localparam int unsigned DEPTH  = 2 ** ADDR_BITWIDTH;
  localparam int unsigned CNT_W  = ADDR_BITWIDTH + 1;

  if (DATA_BITWIDTH % LANE_BITWIDTH != 0) begin : g_width_check
    $error("DATA_BITWIDTH must be a multiple of LANE_BITWIDTH");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic                     clearing_c;
  logic                     user_wr_c;
  logic [NLANES-1:0]        lane_we_c;
  logic [ADDR_BITWIDTH-1:0] wa_c;
  logic [DATA_BITWIDTH-1:0] wd_c;
  logic [DATA_BITWIDTH-1:0] rd_s_c;
  logic [DATA_BITWIDTH-1:0] rd_d_c;
  logic [DATA_BITWIDTH-1:0] merged_c;
  logic [DATA_BITWIDTH-1:0] byp_s_c;
  logic [DATA_BITWIDTH-1:0] byp_d_c;

  // Write-port mux: the clear sequencer owns the array while busy.
  always_comb begin
    clearing_c = (state == ST_CLEAR);
    user_wr_c  = !clearing_c && bus.we;
    lane_we_c  = '0;
    wa_c       = bus.a;
    wd_c       = bus.di;
    if (clearing_c) begin
      lane_we_c = '1;
      wa_c      = cnt[ADDR_BITWIDTH-1:0];
      wd_c      = CLEAR_VALUE;
    end else begin
      lane_we_c = {NLANES{user_wr_c}} & bus.be;
    end
  end

  // Read-during-write bypass; port s always shares the write address.
  always_comb begin
    merged_c = rd_s_c;
    for (int i = 0; i < NLANES; i++) begin
      if (bus.be[i]) merged_c[i*LANE_BITWIDTH +: LANE_BITWIDTH] = bus.di[i*LANE_BITWIDTH +: LANE_BITWIDTH];
    end
    byp_s_c = rd_s_c;
    byp_d_c = rd_d_c;
    if (RDW_MODE == RDW_WRITE_FIRST && user_wr_c) begin
      byp_s_c = merged_c;
      if (bus.dpra == bus.a) byp_d_c = merged_c;
    end
  end

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    rams_dist_lane #(
      .WIDTH         (LANE_BITWIDTH),
      .ADDR_BITWIDTH (ADDR_BITWIDTH)
    ) u_lane (
      .clk (clk),
      .we  (lane_we_c[i]),
      .wa  (wa_c),
      .wd  (wd_c[i*LANE_BITWIDTH +: LANE_BITWIDTH]),
      .ra0 (bus.a),
      .ra1 (bus.dpra),
      .rd0 (rd_s_c[i*LANE_BITWIDTH +: LANE_BITWIDTH]),
      .rd1 (rd_d_c[i*LANE_BITWIDTH +: LANE_BITWIDTH])
    );
  end

  // Clear FSM and registered read outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_CLEAR;
      cnt         <= '0;
      bus.busy    <= 1'b1;
      bus.spo     <= '0;
      bus.dpo     <= '0;
      bus.spo_vld <= 1'b0;
      bus.dpo_vld <= 1'b0;
    end else begin
      bus.spo_vld <= 1'b0;
      bus.dpo_vld <= 1'b0;
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DEPTH - 1)) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.re_s) begin
            bus.spo     <= byp_s_c;
            bus.spo_vld <= 1'b1;
          end
          if (bus.re_d) begin
            bus.dpo     <= byp_d_c;
            bus.dpo_vld <= 1'b1;
          end
          if (bus.clr) begin
            state    <= ST_CLEAR;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        default: begin
          state    <= ST_CLEAR;
          cnt      <= '0;
          bus.busy <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rams_dist_clr.sv
// Scoreboard bench: read-first and write-first instances driven identically.
module tb_rams_dist_clr;
  import rams_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned LW    = 8;
  localparam int unsigned NL    = DW / LW;
  localparam int unsigned DEPTH = 256;

  typedef logic [DW-1:0] word_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rams_dist_clr_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .LANE_BITWIDTH(LW)) ifa ();
  rams_dist_clr_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .LANE_BITWIDTH(LW)) ifb ();

  rams_dist_clr #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .LANE_BITWIDTH(LW),
    .RDW_MODE(RDW_READ_FIRST), .CLEAR_VALUE('0)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

  rams_dist_clr #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .LANE_BITWIDTH(LW),
    .RDW_MODE(RDW_WRITE_FIRST), .CLEAR_VALUE('0)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  // Reference model: contents, remaining clear cycles, held output values.
  word_t mem [DEPTH];
  int    clear_left;
  logic  exp_busy;
  word_t hold [4];
  word_t q_exp [4][$];
  bit    mon_en = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string name, input word_t act, input word_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_port(input int idx, input string name, input logic vld, input word_t act);
    if (vld === 1'b1) begin
      if (q_exp[idx].size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_vld: got 1 expected 0 at %0t", name, $time);
      end else begin
        chk(name, act, q_exp[idx].pop_front());
      end
    end else begin
      if (q_exp[idx].size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_vld: got %b expected 1 at %0t", name, vld, $time);
        void'(q_exp[idx].pop_front());
      end
      chk({name, "_hold"}, act, hold[idx]);
    end
  endtask

  // Monitor: compares DUT outputs between active edges.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy_a", word_t'(ifa.busy), word_t'(exp_busy));
      chk("busy_b", word_t'(ifb.busy), word_t'(exp_busy));
      mon_port(0, "spo_a", ifa.spo_vld, ifa.spo);
      mon_port(1, "spo_b", ifb.spo_vld, ifb.spo);
      mon_port(2, "dpo_a", ifa.dpo_vld, ifa.dpo);
      mon_port(3, "dpo_b", ifb.dpo_vld, ifb.dpo);
    end
  end

  // Drive one cycle of stimulus on both instances and advance the model.
  task automatic apply(input logic r, input logic c, input logic w, input logic [NL-1:0] b,
                       input logic [AW-1:0] ad, input word_t d, input logic rs,
                       input logic [AW-1:0] dp, input logic rd);
    word_t old_s, old_d, merged, v;
    logic  wr;
    @(negedge clk);
    #1;
    rst_n = r;
    ifa.clr = c; ifa.we = w; ifa.be = b; ifa.a = ad; ifa.di = d;
    ifa.re_s = rs; ifa.dpra = dp; ifa.re_d = rd;
    ifb.clr = c; ifb.we = w; ifb.be = b; ifb.a = ad; ifb.di = d;
    ifb.re_s = rs; ifb.dpra = dp; ifb.re_d = rd;
    if (!r) begin
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      for (int i = 0; i < 4; i++) hold[i] = '0;
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      old_s  = mem[ad];
      old_d  = mem[dp];
      merged = old_s;
      for (int i = 0; i < NL; i++)
        if (b[i]) merged[i*LW +: LW] = d[i*LW +: LW];
      wr = w && (b != '0);
      if (rs) begin
        q_exp[0].push_back(old_s); hold[0] = old_s;
        v = wr ? merged : old_s;
        q_exp[1].push_back(v); hold[1] = v;
      end
      if (rd) begin
        q_exp[2].push_back(old_d); hold[2] = old_d;
        v = (wr && dp == ad) ? merged : old_d;
        q_exp[3].push_back(v); hold[3] = v;
      end
      if (wr) mem[ad] = merged;
      if (c) begin
        clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      end
    end
    exp_busy = (clear_left != 0);
    mon_en = 1'b1;
  endtask

  task automatic idle();
    apply(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic write(input logic [AW-1:0] ad, input word_t d, input logic [NL-1:0] b);
    apply(1'b1, 1'b0, 1'b1, b, ad, d, 1'b0, '0, 1'b0);
  endtask

  task automatic read(input logic [AW-1:0] as, input logic [AW-1:0] ad);
    apply(1'b1, 1'b0, 1'b0, '0, as, '0, 1'b1, ad, 1'b1);
  endtask

  // Random accesses, all of which must be dropped while busy.
  task automatic junk(input int n);
    for (int i = 0; i < n; i++)
      apply(1'b1, 1'b1, 1'b1, NL'($urandom), AW'($urandom), word_t'($urandom),
            1'b1, AW'($urandom), 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.clr = 0; ifa.we = 0; ifa.be = '0; ifa.a = '0; ifa.di = '0;
    ifa.re_s = 0; ifa.dpra = '0; ifa.re_d = 0;
    ifb.clr = 0; ifb.we = 0; ifb.be = '0; ifb.a = '0; ifb.di = '0;
    ifb.re_s = 0; ifb.dpra = '0; ifb.re_d = 0;

    // Reset, then the power-up clear with attempted accesses.
    apply(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    junk(DEPTH);
    read(8'd0, 8'd127);
    read(8'd255, 8'd0);
    read(8'd127, 8'd255);

    // Lane-enable merge.
    write(8'd5, 32'hAABBCCDD, 4'b1111);
    write(8'd5, 32'h11223344, 4'b0101);
    read(8'd5, 8'd5);

    // Read-during-write on both ports.
    write(8'd9, 32'h10, 4'b1111);
    apply(1'b1, 1'b0, 1'b1, 4'b1111, 8'd9, 32'h20, 1'b1, 8'd9, 1'b1);
    read(8'd9, 8'd9);
    apply(1'b1, 1'b0, 1'b1, 4'b0010, 8'd9, 32'h0000_7700, 1'b1, 8'd9, 1'b1);

    // Port d holds its last value while writes continue.
    write(8'd20, 32'h5A, 4'b1111);
    read(8'd0, 8'd20);
    for (int i = 0; i < 4; i++) write(8'd20, word_t'($urandom), 4'b1111);
    idle();

    // Requested clear with accesses during busy.
    for (int i = 0; i < 4; i++) write(AW'(i), 32'hFFFF_FFFF, 4'b1111);
    apply(1'b1, 1'b1, 1'b1, 4'b1111, 8'd2, 32'h1234_5678, 1'b1, 8'd3, 1'b1);
    junk(DEPTH);
    for (int i = 0; i < DEPTH; i++) read(AW'(i), AW'(DEPTH - 1 - i));

    // Reset in the middle of a clear restarts the sequence.
    write(8'd1, 32'hCAFE_F00D, 4'b1111);
    apply(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    junk(100);
    apply(1'b0, 1'b1, 1'b1, 4'b1111, 8'd1, 32'hDEAD_BEEF, 1'b1, 8'd1, 1'b1);
    junk(DEPTH);
    read(8'd1, 8'd1);

    // Randomised traffic on a small address window for frequent collisions.
    for (int i = 0; i < 800; i++)
      apply(1'b1, ($urandom_range(0, 299) == 0), 1'($urandom), NL'($urandom),
            AW'($urandom_range(0, 7)), word_t'($urandom), 1'($urandom),
            AW'($urandom_range(0, 7)), 1'($urandom));

    idle();
    idle();
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
